maze_mem_arb: RTL and testbench
===============================

MAZE_MEM_ARB -- requirements
Module: maze_mem_arb

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1: synchronous, active-low reset.
REQ-003 SHALL have port s_req, input, 1: solver requests a maze-memory access.
REQ-004 SHALL have ports s_wr (input, 1), s_row (input, 4), s_col (input, 4) and s_wdata (input, 1): solver write flag, cell address and write data.
REQ-005 SHALL have ports s_gnt (output, 1), s_rdata (output, 1) and s_valid (output, 1): solver grant, read data and read-data-valid.
REQ-006 SHALL have ports h_req, h_wr, h_row, h_col, h_wdata, h_gnt, h_rdata and h_valid: host loader port, with widths and directions identical to the solver port.
REQ-007 SHALL have ports m_row (output, 4), m_col (output, 4), m_write (output, 1) and m_wdata (output, 1): maze-memory address, write strobe and write data.
REQ-008 SHALL have port m_rdata, input, 1: combinational memory read data for the current m_row/m_col.
REQ-009 SHALL have port busy, output, 1: high while any grant is active.

Function
REQ-010 SHALL implement FSM states IDLE, SERV_S and SERV_H, encoded in 2 bits.
REQ-011 In IDLE with any request pending, the arbiter SHALL choose a winner per REQ-019/REQ-020 and enter SERV_S or SERV_H on the next edge.
REQ-012 In SERV_x, gnt_x SHALL be 1 and m_row, m_col, m_wdata SHALL be driven combinationally from port x.
REQ-013 In SERV_x, m_write SHALL equal x_wr; each cycle with gnt_x=1 is exactly one transaction.
REQ-014 For a read granted in cycle N, x_rdata SHALL carry m_rdata registered at edge N+1, with x_valid=1 for exactly cycle N+1.
REQ-015 For a write transaction, x_valid SHALL stay 0.
REQ-016 A burst counter (3 bits) SHALL count consecutive transactions to the same port, cleared on every grant change.
REQ-017 While in SERV_x with x_req=1, the grant SHALL stay with x unless the counter has reached 4 and the other port is requesting; in that case the grant SHALL switch to the other port on the next edge.
REQ-018 In SERV_x with x_req=0, the arbiter SHALL switch to the other port if it is requesting, otherwise return to IDLE, on the next edge.
REQ-019 On simultaneous new requests from IDLE, the winner SHALL be selected per the Configuration rule.
REQ-020 A requester SHALL hold req and its address/data stable until it sees gnt; the arbiter does not latch requests.
REQ-021 s_gnt and h_gnt SHALL never both be 1.
REQ-022 m_write SHALL be 0 whenever no grant is active.
REQ-023 busy SHALL equal s_gnt OR h_gnt.
REQ-024 Address fields SHALL pass through unmodified, covering all 16x16 cells; no wrap or bounds check is performed.

Reset
REQ-025 With RST=0 at an edge, the FSM SHALL enter IDLE, the counter SHALL clear to 0, last-winner SHALL be set to host, and all outputs SHALL be 0, including the valids and rdata registers.
REQ-026 A reset during SERV_x SHALL abort the current transaction with no valid pulse.
REQ-027 A write granted in the reset cycle SHALL not be issued, because m_write is forced to 0 while RST=0.

Configuration
REQ-028 The macro MAZE_ARB_RR_EN SHALL select the tie-break rule in IDLE.
REQ-029 With MAZE_ARB_RR_EN defined, a tie SHALL go to the port that did not win last (round robin).
REQ-030 Without MAZE_ARB_RR_EN, the host SHALL always win ties (fixed priority); the burst limit of REQ-017 still applies in both builds.

Verification
REQ-031 Reset: hold RST=0 for 2 cycles with both requests high -> s_gnt=h_gnt=m_write=busy=0, FSM in IDLE.
REQ-032 Solver read: s_req=1, s_wr=0, row=3, col=5, memory cell=1 -> s_gnt=1 in cycle 2, s_valid=1 and s_rdata=1 in cycle 3.
REQ-033 Host writes: h_req=1 for 3 writes, row=0, col=0..2, wdata=1 -> m_write=1 for exactly 3 cycles, then FSM returns to IDLE.
REQ-034 Burst limit: both requests held high, solver granted first -> grants alternate every 4 transactions, gnt signals never overlap.
REQ-035 Tie: both requests rise together from reset -> with MAZE_ARB_RR_EN the solver wins first (last winner is host); without it the host wins.
REQ-036 Reset mid-read: assert RST=0 in the grant cycle -> no valid pulse in the next cycle, FSM in IDLE, counter cleared to 0.

Source files
------------

// File: rtl/maze_mem_arb.sv
// Two-port arbiter in front of the 16x16 single-bit maze memory.
// The solver (s_*) and the host loader (h_*) share one memory port; each granted
// cycle is one transaction, reads return one cycle later on x_rdata/x_valid.
// A grant may be held for at most 4 consecutive transactions while the other
// port is waiting.
// Optional build macro MAZE_ARB_RR_EN: round-robin tie-break from idle instead
// of the default fixed host priority.
module maze_mem_arb (
  input  logic       clk,
  input  logic       RST,
  // solver port
  input  logic       s_req,
  input  logic       s_wr,
  input  logic [3:0] s_row,
  input  logic [3:0] s_col,
  input  logic       s_wdata,
  output logic       s_gnt,
  output logic       s_rdata,
  output logic       s_valid,
  // host loader port
  input  logic       h_req,
  input  logic       h_wr,
  input  logic [3:0] h_row,
  input  logic [3:0] h_col,
  input  logic       h_wdata,
  output logic       h_gnt,
  output logic       h_rdata,
  output logic       h_valid,
  // maze memory
  output logic [3:0] m_row,
  output logic [3:0] m_col,
  output logic       m_write,
  output logic       m_wdata,
  input  logic       m_rdata,
  output logic       busy
);

  localparam logic [2:0] BurstLimit = 3'd4;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StServS = 2'b01,
    StServH = 2'b10
  } state_e;

  state_e     state_q;
  logic [2:0] cnt_q;
  logic [2:0] cnt_inc;
  logic       burst_full;
  logic       tie_h;
  logic       pick_h;
  logic       s_rdata_q, s_valid_q;
  logic       h_rdata_q, h_valid_q;
  logic       sel_wr;

  // Grants decode straight from the state register, so they can never overlap.
  assign s_gnt   = (state_q == StServS);
  assign h_gnt   = (state_q == StServH);
  assign busy    = s_gnt | h_gnt;
  assign s_rdata = s_rdata_q;
  assign s_valid = s_valid_q;
  assign h_rdata = h_rdata_q;
  assign h_valid = h_valid_q;

  // Counter saturates at the limit; the transaction in flight is included.
  assign cnt_inc    = (cnt_q >= BurstLimit) ? BurstLimit : cnt_q + 3'd1;
  assign burst_full = (cnt_inc == BurstLimit);

`ifdef MAZE_ARB_RR_EN
  logic last_h_q;

  // Remember which port held the memory most recently (host after reset).
  always_ff @(posedge clk) begin
    if (!RST) begin
      last_h_q <= 1'b1;
    end else if (s_gnt) begin
      last_h_q <= 1'b0;
    end else if (h_gnt) begin
      last_h_q <= 1'b1;
    end
  end

  assign tie_h = ~last_h_q;
`else
  assign tie_h = 1'b1;
`endif

  // Winner when leaving idle: the only requester, or the tie-break choice.
  assign pick_h = h_req & (~s_req | tie_h);

  // Route the granted port onto the memory; write is killed while in reset.
  always_comb begin
    m_row   = 4'd0;
    m_col   = 4'd0;
    m_wdata = 1'b0;
    sel_wr  = 1'b0;
    if (s_gnt) begin
      m_row   = s_row;
      m_col   = s_col;
      m_wdata = s_wdata;
      sel_wr  = s_wr;
    end else if (h_gnt) begin
      m_row   = h_row;
      m_col   = h_col;
      m_wdata = h_wdata;
      sel_wr  = h_wr;
    end
  end

  assign m_write = sel_wr & RST;

  // Arbitration FSM, burst counter and registered read returns.
  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      s_rdata_q <= 1'b0;
      s_valid_q <= 1'b0;
      h_rdata_q <= 1'b0;
      h_valid_q <= 1'b0;
    end else begin
      s_valid_q <= s_gnt & ~s_wr;
      h_valid_q <= h_gnt & ~h_wr;
      if (s_gnt && !s_wr) begin
        s_rdata_q <= m_rdata;
      end
      if (h_gnt && !h_wr) begin
        h_rdata_q <= m_rdata;
      end

      case (state_q)
        StIdle: begin
          cnt_q <= 3'd0;
          if (s_req || h_req) begin
            state_q <= pick_h ? StServH : StServS;
          end
        end
        StServS: begin
          if (s_req && !(burst_full && h_req)) begin
            cnt_q <= cnt_inc;
          end else if (h_req) begin
            state_q <= StServH;
            cnt_q   <= 3'd0;
          end else begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
          end
        end
        StServH: begin
          if (h_req && !(burst_full && s_req)) begin
            cnt_q <= cnt_inc;
          end else if (s_req) begin
            state_q <= StServS;
            cnt_q   <= 3'd0;
          end else begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maze_mem_arb.sv
// Directed bench for maze_mem_arb with a behavioural maze memory and a read
// scoreboard per port (expected bit queued when a read is granted, popped on valid).
module tb_maze_mem_arb;

  logic       clk;
  logic       RST;
  logic       s_req, s_wr, s_wdata;
  logic [3:0] s_row, s_col;
  logic       s_gnt, s_rdata, s_valid;
  logic       h_req, h_wr, h_wdata;
  logic [3:0] h_row, h_col;
  logic       h_gnt, h_rdata, h_valid;
  logic [3:0] m_row, m_col;
  logic       m_write, m_wdata, m_rdata;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int wcount = 0;
  bit mon_en = 0;
  logic s_pend = 1'b0;
  logic h_pend = 1'b0;
  logic sq[$];
  logic hq[$];

  localparam logic [255:0] Preload = (256'd1 << 53) | (256'd1 << 154);
  logic [255:0] mem;

  maze_mem_arb dut (
    .clk     (clk),
    .RST     (RST),
    .s_req   (s_req),
    .s_wr    (s_wr),
    .s_row   (s_row),
    .s_col   (s_col),
    .s_wdata (s_wdata),
    .s_gnt   (s_gnt),
    .s_rdata (s_rdata),
    .s_valid (s_valid),
    .h_req   (h_req),
    .h_wr    (h_wr),
    .h_row   (h_row),
    .h_col   (h_col),
    .h_wdata (h_wdata),
    .h_gnt   (h_gnt),
    .h_rdata (h_rdata),
    .h_valid (h_valid),
    .m_row   (m_row),
    .m_col   (m_col),
    .m_write (m_write),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Maze memory model: combinational read, write on the rising edge.
  assign m_rdata = mem[{m_row, m_col}];
  always @(posedge clk) begin
    if (!RST) mem <= Preload;
    else if (m_write) mem[{m_row, m_col}] <= m_wdata;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Protocol monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("s_valid", {7'd0, s_valid}, {7'd0, s_pend});
      if (s_valid && sq.size() != 0) chk("s_rdata_sb", {7'd0, s_rdata}, {7'd0, sq.pop_front()});
      chk("h_valid", {7'd0, h_valid}, {7'd0, h_pend});
      if (h_valid && hq.size() != 0) chk("h_rdata_sb", {7'd0, h_rdata}, {7'd0, hq.pop_front()});
      s_pend = s_gnt && !s_wr && RST;
      h_pend = h_gnt && !h_wr && RST;
      if (s_pend) sq.push_back(mem[{s_row, s_col}]);
      if (h_pend) hq.push_back(mem[{h_row, h_col}]);
      chk("gnt_excl", {7'd0, s_gnt & h_gnt}, 8'd0);
      chk("busy", {7'd0, busy}, {7'd0, s_gnt | h_gnt});
      if (!busy) chk("mwr_idle", {7'd0, m_write}, 8'd0);
      if (m_write && RST) wcount++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held two cycles with both ports requesting writes.
    RST = 1'b0;
    s_req = 1'b1; s_wr = 1'b1; s_row = 4'd0; s_col = 4'd0; s_wdata = 1'b1;
    h_req = 1'b1; h_wr = 1'b1; h_row = 4'd0; h_col = 4'd0; h_wdata = 1'b0;
    tick();
    tick();
    chk("rst_s_gnt", {7'd0, s_gnt}, 8'd0);
    chk("rst_h_gnt", {7'd0, h_gnt}, 8'd0);
    chk("rst_m_write", {7'd0, m_write}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_s_valid", {7'd0, s_valid}, 8'd0);
    chk("rst_h_valid", {7'd0, h_valid}, 8'd0);
    mon_en = 1;

    // Tie straight out of reset.
    s_wr = 1'b0; h_wr = 1'b0; RST = 1'b1;
    tick();
`ifdef MAZE_ARB_RR_EN
    chk("tie_s_gnt", {7'd0, s_gnt}, 8'd1);
    chk("tie_h_gnt", {7'd0, h_gnt}, 8'd0);
`else
    chk("tie_s_gnt", {7'd0, s_gnt}, 8'd0);
    chk("tie_h_gnt", {7'd0, h_gnt}, 8'd1);
`endif
    s_req = 1'b0; h_req = 1'b0;
    tick();
    chk("tie_idle", {7'd0, busy}, 8'd0);

    // Solver read of cell (3,5) which holds 1.
    s_req = 1'b1; s_row = 4'd3; s_col = 4'd5;
    #1;
    chk("rd_gnt_c1", {7'd0, s_gnt}, 8'd0);
    tick();
    chk("rd_gnt_c2", {7'd0, s_gnt}, 8'd1);
    chk("rd_m_row", {4'd0, m_row}, 8'd3);
    chk("rd_m_col", {4'd0, m_col}, 8'd5);
    chk("rd_m_write", {7'd0, m_write}, 8'd0);
    s_req = 1'b0;
    tick();
    chk("rd_valid_c3", {7'd0, s_valid}, 8'd1);
    chk("rd_rdata_c3", {7'd0, s_rdata}, 8'd1);
    chk("rd_gnt_c3", {7'd0, s_gnt}, 8'd0);

    // Host writes 1 to (0,0), (0,1), (0,2).
    wcount = 0;
    h_req = 1'b1; h_wr = 1'b1; h_wdata = 1'b1; h_row = 4'd0; h_col = 4'd0;
    tick();
    for (int c = 0; c < 3; c++) begin
      h_col = 4'(c);
      if (c == 2) h_req = 1'b0;
      #1;
      chk("wr_h_gnt", {7'd0, h_gnt}, 8'd1);
      chk("wr_m_write", {7'd0, m_write}, 8'd1);
      chk("wr_m_col", {4'd0, m_col}, 8'(c));
      tick();
    end
    chk("wr_idle_busy", {7'd0, busy}, 8'd0);
    chk("wr_idle_m_write", {7'd0, m_write}, 8'd0);
    h_wr = 1'b0;
    chk("wr_count", 8'(wcount), 8'd3);

    // Read back one written cell through the solver.
    s_req = 1'b1; s_row = 4'd0; s_col = 4'd1;
    tick();
    s_req = 1'b0;
    tick();
    chk("rb_valid", {7'd0, s_valid}, 8'd1);
    chk("rb_rdata", {7'd0, s_rdata}, 8'd1);

    // Burst limit: solver first, then both held high.
    s_req = 1'b1; s_row = 4'd9; s_col = 4'd10;
    tick();
    h_req = 1'b1; h_row = 4'd0; h_col = 4'd2;
    for (int i = 0; i < 16; i++) begin
      logic exp_s;
      exp_s = ((i / 4) % 2) == 0;
      #1;
      chk("burst_s_gnt", {7'd0, s_gnt}, {7'd0, exp_s});
      chk("burst_h_gnt", {7'd0, h_gnt}, {7'd0, ~exp_s});
      tick();
    end
    s_req = 1'b0; h_req = 1'b0;
    tick();
    chk("burst_end_idle", {7'd0, busy}, 8'd0);

    // Write granted in a reset cycle must not reach the memory.
    h_req = 1'b1; h_wr = 1'b1; h_row = 4'd1; h_col = 4'd1;
    tick();
    chk("rstwr_h_gnt", {7'd0, h_gnt}, 8'd1);
    chk("rstwr_pre", {7'd0, m_write}, 8'd1);
    RST = 1'b0;
    #1;
    chk("rstwr_m_write", {7'd0, m_write}, 8'd0);
    h_req = 1'b0;
    tick();
    chk("rstwr_idle", {7'd0, busy}, 8'd0);
    RST = 1'b1; h_wr = 1'b0;

    // Reset in the grant cycle of a read: no valid pulse, back to idle.
    s_req = 1'b1; s_row = 4'd3; s_col = 4'd5;
    tick();
    chk("rstrd_gnt", {7'd0, s_gnt}, 8'd1);
    RST = 1'b0; s_req = 1'b0;
    tick();
    chk("rstrd_valid", {7'd0, s_valid}, 8'd0);
    chk("rstrd_busy", {7'd0, busy}, 8'd0);
    RST = 1'b1; s_req = 1'b1;
    tick();
    chk("post_rst_gnt", {7'd0, s_gnt}, 8'd1);
    s_req = 1'b0;
    tick();
    chk("post_rst_valid", {7'd0, s_valid}, 8'd1);
    chk("post_rst_rdata", {7'd0, s_rdata}, 8'd1);
    tick();
    chk("sb_s_left", 8'(sq.size()), 8'd0);
    chk("sb_h_left", 8'(hq.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
